// File: rtl/snn_axi_pkg.sv
// snn_axi_pkg: shared constants, state encodings and helpers for the SNN AXI4-Lite slave.
package snn_axi_pkg;
    localparam logic [15:0] CTRL_REG       = 16'h0000;
    localparam logic [15:0] SIM_TIME_REG   = 16'h0004;
    localparam logic [15:0] MEM_CFG_REG    = 16'h0008;
    localparam logic [15:0] DEBUG_REG      = 16'h000C;
    localparam logic [15:0] EXT_MEM_OFFSET = 16'h0100;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MEM_SEL_NONE  = 2'd0,
        MEM_SEL_SYN   = 2'd1,
        MEM_SEL_SPIKE = 2'd2,
        MEM_SEL_CNT   = 2'd3
    } mem_sel_e;

    typedef enum logic [1:0] {
        IDX_CTRL     = 2'd0,
        IDX_SIM_TIME = 2'd1,
        IDX_MEM_CFG  = 2'd2,
        IDX_DEBUG    = 2'd3
    } reg_idx_e;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} r_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i+:8] = strb[i] ? new_v[8*i+:8] : old_v[8*i+:8];
        return res;
    endfunction
endpackage

// File: rtl/snn_axi_if.sv
// snn_axi_if: AXI4-Lite bus bundle between the host interconnect and the SNN config slave.
interface snn_axi_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/snn_axi_addr_decode.sv
// snn_axi_addr_decode: classifies a byte address as register, memory window or unmapped.
module snn_axi_addr_decode
    import snn_axi_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0] addr,
    output logic [1:0]    reg_idx,
    output logic          is_mem,
    output logic          is_err
);
    logic is_reg;

    always_comb begin
        reg_idx = addr == AW'(SIM_TIME_REG) ? IDX_SIM_TIME :
                  addr == AW'(MEM_CFG_REG)  ? IDX_MEM_CFG  :
                  addr == AW'(DEBUG_REG)    ? IDX_DEBUG    : IDX_CTRL;
        is_reg  = addr == AW'(CTRL_REG) || addr == AW'(SIM_TIME_REG) ||
                  addr == AW'(MEM_CFG_REG) || addr == AW'(DEBUG_REG);
        is_mem  = (addr & ~AW'(8'hFF)) == AW'(EXT_MEM_OFFSET);
        is_err  = !is_reg && !is_mem;
    end
endmodule

// File: rtl/snn_axi_lite_slave.sv
// snn_axi_lite_slave: AXI4-Lite config slave for the SNN core; holds control registers and
// forwards the 0x0100 window to the core memory selected by MEM_CFG.
module snn_axi_lite_slave
    import snn_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int MAX_TIMESTEPS_BITS = 7
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    snn_axi_if.slave                      s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
    output logic                          start,
    output logic [MAX_TIMESTEPS_BITS-1:0] sim_time,
    output logic [C_S_AXI_DATA_WIDTH-1:0] mem_cfg,
    output logic                          mem_we,
    output logic                          mem_re,
    output logic [7:0]                    mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata,
    input  logic                          busy
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    w_state_e        w_state;
    r_state_e        r_state;
    logic            aw_got, w_got;
    logic [AW-1:0]   aw_addr_q, waddr;
    logic [DW-1:0]   w_data_q, wdat, sim_time_q, reg_rdata;
    logic [DW/8-1:0] w_strb_q, wstb;
    logic [15:0]     wr_cnt;
    logic [1:0]      w_idx, r_idx;
    logic            w_mem, w_err, w_bad, r_mem, r_err, w_go, r_go;

    // AW and W are captured independently, so either may arrive first
    assign waddr = aw_got ? aw_addr_q : s_axi.awaddr;
    assign wdat  = w_got ? w_data_q : s_axi.wdata;
    assign wstb  = w_got ? w_strb_q : s_axi.wstrb;

    snn_axi_addr_decode #(.AW(AW)) u_wdec (.addr(waddr), .reg_idx(w_idx), .is_mem(w_mem), .is_err(w_err));
    snn_axi_addr_decode #(.AW(AW)) u_rdec (.addr(s_axi.araddr), .reg_idx(r_idx), .is_mem(r_mem), .is_err(r_err));

    assign w_go  = w_state == W_IDLE && (aw_got || s_axi.awvalid) && (w_got || s_axi.wvalid);
    // a window write owns the memory port; a colliding window read waits a cycle
    assign r_go  = r_state == R_IDLE && s_axi.arvalid && !(r_mem && w_go && w_mem);
    assign w_bad = w_err || (!w_mem && w_idx == IDX_DEBUG);
    assign sim_time  = sim_time_q[MAX_TIMESTEPS_BITS-1:0];
    assign reg_rdata = r_idx == IDX_CTRL     ? ctrl       :
                       r_idx == IDX_SIM_TIME ? sim_time_q :
                       r_idx == IDX_MEM_CFG  ? mem_cfg    : {busy, 15'b0, wr_cnt};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_IDLE;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
            ctrl          <= '0;
            sim_time_q    <= '0;
            mem_cfg       <= '0;
            start         <= 1'b0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            wr_cnt        <= '0;
        end else begin
            start  <= 1'b0;
            mem_we <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (s_axi.awvalid && !aw_got) begin
                        aw_got    <= 1'b1;
                        aw_addr_q <= s_axi.awaddr;
                    end
                    if (s_axi.wvalid && !w_got) begin
                        w_got    <= 1'b1;
                        w_data_q <= s_axi.wdata;
                        w_strb_q <= s_axi.wstrb;
                    end
                    if (w_go) begin
                        w_state       <= W_EXEC;
                        aw_got        <= 1'b0;
                        w_got         <= 1'b0;
                        s_axi.awready <= 1'b1;
                        s_axi.wready  <= 1'b1;
                        s_axi.bresp   <= w_bad ? RESP_SLVERR : RESP_OKAY;
                        if (w_mem) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= wdat;
                            wr_cnt    <= wr_cnt + 16'd1;
                        end else if (!w_bad) begin
                            if (w_idx == IDX_CTRL) begin
                                ctrl  <= apply_wstrb(ctrl, wdat, wstb);
                                start <= wdat[0];
                            end
                            if (w_idx == IDX_SIM_TIME) sim_time_q <= apply_wstrb(sim_time_q, wdat, wstb);
                            if (w_idx == IDX_MEM_CFG) mem_cfg <= apply_wstrb(mem_cfg, wdat, wstb);
                        end
                    end
                end
                W_EXEC: begin
                    s_axi.awready <= 1'b0;
                    s_axi.wready  <= 1'b0;
                    s_axi.bvalid  <= 1'b1;
                    w_state       <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_IDLE;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
            s_axi.rresp   <= RESP_OKAY;
            mem_re        <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (r_go) begin
                        s_axi.arready <= 1'b1;
                        if (r_mem) begin
                            mem_re  <= 1'b1;
                            r_state <= R_MEM;
                        end else begin
                            s_axi.rdata <= r_err ? '0 : reg_rdata;
                            s_axi.rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                            r_state     <= R_DATA;
                        end
                    end
                end
                // first cycle issues mem_re, second captures the returned word
                R_MEM: begin
                    s_axi.arready <= 1'b0;
                    if (!mem_re) begin
                        s_axi.rdata  <= mem_rdata;
                        s_axi.rresp  <= RESP_OKAY;
                        s_axi.rvalid <= 1'b1;
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    s_axi.arready <= 1'b0;
                    if (!s_axi.rvalid) s_axi.rvalid <= 1'b1;
                    else if (s_axi.rready) begin
                        s_axi.rvalid <= 1'b0;
                        r_state      <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) mem_addr <= '0;
        else if (w_go && w_mem) mem_addr <= waddr[7:0];
        else if (r_go && r_mem) mem_addr <= s_axi.araddr[7:0];
    end
endmodule

// File: tb/tb_snn_axi_lite_slave.sv
// tb_snn_axi_lite_slave: directed checks of the SNN AXI4-Lite slave against hand-computed values.
module tb_snn_axi_lite_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_axi_if #(.AW(16), .DW(32)) bus ();

    logic [31:0] ctrl, mem_cfg, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_model_val = '0;
    logic [6:0]  sim_time;
    logic [7:0]  mem_addr;
    logic        start, mem_we, mem_re;
    logic        busy = 1'b0;

    int checks = 0, failures = 0;
    int start_cnt = 0, we_cnt = 0, overlap = 0;
    logic [7:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;

    snn_axi_lite_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .MAX_TIMESTEPS_BITS(7)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
        .ctrl(ctrl), .start(start), .sim_time(sim_time), .mem_cfg(mem_cfg),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // memory model returns its word one cycle after mem_re; monitor tallies strobes
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_model_val;
        if (start) start_cnt++;
        if (mem_we) begin
            we_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (mem_we && mem_re) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        bit aw_done;
        aw_done = 0;
        @(negedge clk);
        bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1; bus.bready = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (aw_done) begin bus.awvalid = 0; bus.wvalid = 0; end
            if (bus.awready) aw_done = 1;
        end while (!bus.bvalid && lat < 50);
        if (!bus.bvalid) check("wr_timeout", {31'b0, bus.bvalid}, 1);
        resp = bus.bresp;
        @(negedge clk);
        bus.bready = 0; bus.awvalid = 0; bus.wvalid = 0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        bit ar_done;
        ar_done = 0;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (ar_done) bus.arvalid = 0;
            if (bus.arready) ar_done = 1;
        end while (!bus.rvalid && lat < 50);
        if (!bus.rvalid) check("rd_timeout", {31'b0, bus.rvalid}, 1);
        d = bus.rdata;
        resp = bus.rresp;
        @(negedge clk);
        bus.rready = 0; bus.arvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        int          lat, wlat, n, we0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_ready_valid", {28'b0, bus.awready, bus.wready, bus.bvalid, bus.rvalid}, 0);
        check("rst_regs", ctrl | mem_cfg | {25'b0, sim_time}, 0);
        check("rst_strobes", {29'b0, start, mem_we, mem_re}, 0);

        axi_write(16'h0000, 32'hDEADBEEF, 4'hF, rsp, wlat);
        check("ctrl_bresp", {30'b0, rsp}, 0);
        check("ctrl_wlat", wlat, 2);
        check("start_pulses", start_cnt, 1);
        check("ctrl_out", ctrl, 32'hDEADBEEF);
        axi_read(16'h0000, rd, rsp, lat);
        check("ctrl_rdata", rd, 32'hDEADBEEF);
        check("ctrl_rresp", {30'b0, rsp}, 0);
        check("reg_rlat", lat, 2);

        axi_write(16'h0000, 32'h11223344, 4'b0101, rsp, wlat);
        check("ctrl_wstrb", ctrl, 32'hDE22BE44);
        check("no_start_bit0_clear", start_cnt, 1);

        axi_write(16'h0008, 32'h2, 4'hF, rsp, wlat);
        check("mem_cfg_out", mem_cfg, 32'h2);
        axi_write(16'h0105, 32'h12345678, 4'h0, rsp, wlat);
        check("mem_we_count", we_cnt, 1);
        check("mem_we_addr", {24'b0, last_waddr}, 32'h05);
        check("mem_we_data", last_wdata, 32'h12345678);
        check("mem_bresp", {30'b0, rsp}, 0);
        axi_read(16'h000C, rd, rsp, lat);
        check("debug_cnt1", rd, 32'h1);
        busy = 1;
        axi_read(16'h000C, rd, rsp, lat);
        check("debug_busy", rd, 32'h80000001);
        busy = 0;

        mem_model_val = 32'hA5A5A5A5;
        axi_read(16'h0107, rd, rsp, lat);
        check("mem_rlat", lat, 3);
        check("mem_rdata", rd, 32'hA5A5A5A5);

        we0 = we_cnt;
        @(negedge clk);
        bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1; bus.bready = 0;
        repeat (3) @(negedge clk);
        check("wfirst_no_ready", {30'b0, bus.awready, bus.wready}, 0);
        bus.awaddr = 16'h0110; bus.awvalid = 1;
        @(negedge clk);
        check("wfirst_ready", {30'b0, bus.awready, bus.wready}, 2'b11);
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        n = 0;
        repeat (5) begin
            if (bus.bvalid) n++;
            @(negedge clk);
        end
        check("bvalid_held", n, 5);
        bus.bready = 1;
        @(negedge clk);
        check("bvalid_dropped", {31'b0, bus.bvalid}, 0);
        bus.bready = 0;
        check("wfirst_single_we", we_cnt - we0, 1);
        check("wfirst_addr", {24'b0, last_waddr}, 32'h10);
        check("wfirst_data", last_wdata, 32'h0BADF00D);

        axi_read(16'h0010, rd, rsp, lat);
        check("unmapped_rresp", {30'b0, rsp}, 2'b10);
        check("unmapped_rdata", rd, 0);
        axi_write(16'h000C, 32'hFFFFFFFF, 4'hF, rsp, wlat);
        check("debug_wr_bresp", {30'b0, rsp}, 2'b10);
        axi_read(16'h000C, rd, rsp, lat);
        check("debug_unchanged", rd, 32'h2);

        mem_model_val = 32'h5A5A1234;
        we0 = we_cnt;
        fork
            axi_write(16'h0120, 32'hCAFE0001, 4'hF, rsp, wlat);
            begin
                logic [31:0] crd;
                logic [1:0]  crsp;
                int          clat;
                axi_read(16'h0121, crd, crsp, clat);
                check("contend_rlat", clat, 4);
                check("contend_rdata", crd, 32'h5A5A1234);
            end
        join
        check("contend_we", we_cnt - we0, 1);
        check("no_we_re_overlap", overlap, 0);

        @(negedge clk);
        bus.awaddr = 16'h0000; bus.awvalid = 1; bus.wdata = 32'h100; bus.wstrb = 4'hF; bus.wvalid = 1;
        bus.bready = 0;
        repeat (2) @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        check("wresp_pending", {31'b0, bus.bvalid}, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_wresp_bvalid", {29'b0, bus.bvalid, bus.awready, bus.wready}, 0);
        check("rst_wresp_regs", ctrl | mem_cfg | {25'b0, sim_time}, 0);

        bus.araddr = 16'h0107; bus.arvalid = 1; bus.rready = 1;
        @(negedge clk);
        check("rmem_entered", {30'b0, bus.arready, mem_re}, 2'b11);
        bus.arvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        bus.rready = 0;
        check("rst_rmem_ctl", {29'b0, bus.rvalid, bus.arready, mem_re}, 0);
        check("rst_rmem_data", {bus.rdata[29:0], bus.rresp}, 0);

        axi_write(16'h0004, 32'd100, 4'hF, rsp, wlat);
        check("post_rst_sim_time", {25'b0, sim_time}, 32'd100);
        axi_read(16'h0004, rd, rsp, lat);
        check("post_rst_rd", rd, 32'd100);
        axi_read(16'h000C, rd, rsp, lat);
        check("post_rst_debug", rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/snn_axi_lite_slave.md
# snn_axi_lite_slave

AXI4-Lite responder terminating the host configuration bus of the SNN core. It holds the control, sim-time, memory-config and debug registers and forwards accesses in the external memory window to whichever core memory MEM_CFG selects: synapse weights, spike pattern or spike counters. It sits between the PS/host AXI interconnect and the core datapath inside `snn_core_top`.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 16, byte address width.
- MAX_TIMESTEPS_BITS, 7, width of the `sim_time` output.
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- S_AXI_AWADDR/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY: standard AXI4-Lite write channels.
- S_AXI_ARADDR/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels.
- ctrl  out  32  CTRL register contents.
- start  out  1  one-cycle pulse on any CTRL write with WDATA[0]=1.
- sim_time  out  MAX_TIMESTEPS_BITS  SIM_TIME[MAX_TIMESTEPS_BITS-1:0].
- mem_cfg  out  32  MEM_CFG contents. [1:0] selects the memory: 1 synapse, 2 spike pattern, 3 spike counter. The remaining bits are decoded by the core.
- mem_we  out  1  memory-window write strobe, one cycle.
- mem_re  out  1  memory-window read strobe, one cycle.
- mem_addr  out  8  word index, equal to AxADDR[7:0].
- mem_wdata  out  32  write data, valid with mem_we.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_re.
- busy  in  1  core running flag.

## Operation
- Address map (AxADDR[15:0]):
  - 0x0000 CTRL: R/W.
  - 0x0004 SIM_TIME: R/W.
  - 0x0008 MEM_CFG: R/W.
  - 0x000C DEBUG: read-only. Layout is [31]=busy, [30:16]=0, [15:0]=count of completed memory-window writes, wrapping at 16 bits.
  - 0x0100–0x01FF: memory window. AxADDR[7:0] is a word index, so it is not byte-scaled and not alignment-checked.
- Register decode uses the full 16-bit address.
- Any other address returns RDATA=0 and RESP=SLVERR (2'b10). A write to such an address is ignored. A write to DEBUG is also ignored and returns SLVERR.
- WSTRB is honoured per byte for CTRL, SIM_TIME and MEM_CFG. Memory-window writes ignore WSTRB and write the full word.
- Write FSM states:
  - W_IDLE: AW and W may arrive in either order and each is latched on its own. Once both are latched, go to W_EXEC.
  - W_EXEC: one cycle. Pulse AWREADY and WREADY together, perform the register update or drive mem_we, then go to W_RESP.
  - W_RESP: BVALID=1 until BREADY, then return to W_IDLE.
- Read FSM states:
  - R_IDLE: when ARVALID, pulse ARREADY. A register address goes to R_DATA. A memory address drives mem_re and goes to R_MEM.
  - R_MEM: capture mem_rdata into RDATA, then go to R_DATA.
  - R_DATA: RVALID=1 until RREADY, then return to R_IDLE.
- CTRL stores all 32 bits, including bit 0. `start` is the only side effect of a CTRL write; there is no hardware clearing of bit 0.
- Memory-port contention: mem_we and mem_re are never asserted in the same cycle. If the write FSM would enter W_EXEC for a window address while the read FSM would issue mem_re in the same cycle, the write wins and the read's ARREADY stalls one cycle. Register accesses never stall.

## Timing
- Reset values:
  - All READY/VALID outputs are 0; RESP is 0 and RDATA is 0.
  - ctrl, sim_time and mem_cfg are 0; DEBUG count is 0.
  - start, mem_we and mem_re are 0.
- Reset mid-transaction abandons any latched AW/W/AR with no response issued. Both FSMs return to IDLE on the next edge.
- Write latency, with AWVALID and WVALID high at edge N: AWREADY and WREADY are high in cycle N+1, and BVALID rises at N+2. mem_we, `start` and the register update all fall in cycle N+1.
- Register read, with ARVALID high at edge N: ARREADY is high in N+1 and RVALID in N+2.
- Memory read: ARREADY in N+1 (with mem_re), mem_rdata in N+2, RVALID in N+3.
- BVALID and RVALID hold their data stable until accepted. No new write or read is accepted while the corresponding response is pending.
- Reads and writes proceed concurrently except for the memory-port arbitration above.

## Structure
- Shared package `snn_axi_pkg`:
  - Register offsets CTRL_REG, SIM_TIME_REG, MEM_CFG_REG, DEBUG_REG and EXT_MEM_OFFSET.
  - MEM_SEL encodings.
  - AXI RESP constants.
  - Write and read FSM state enums.
- Sub-module `snn_axi_addr_decode` (combinational) maps an address to {reg_idx, is_mem, is_err}. It is instantiated once per channel.

## Test plan
- Write 0xDEADBEEF to 0x0000, then read 0x0000 → BRESP=0, RDATA=0xDEADBEEF, RRESP=0. `start` pulses exactly one cycle.
- Write 0x2 to MEM_CFG, then write 0x12345678 to 0x0105 → mem_cfg=0x2. mem_we is high for one cycle with mem_addr=0x05 and mem_wdata=0x12345678. DEBUG[15:0] reads 1.
- Memory read at 0x0107 with the model returning 0xA5A5A5A5 → RVALID exactly 3 cycles after ARVALID is sampled, RDATA=0xA5A5A5A5.
- WVALID asserted 3 cycles before AWVALID, then BREADY held low for 5 cycles → a single write occurs and BVALID stays high until BREADY.
- Read of 0x0010 and write to 0x000C → RRESP=2'b10 with RDATA=0, BRESP=2'b10, and the DEBUG count is unchanged.
- Reset asserted while in W_RESP, and separately while in R_MEM → all outputs return to their reset values the next cycle, and a subsequent SIM_TIME write of 100 reads back 100.
